ws2812_rx: RTL

- Single-wire NRZ pulse-width receiver for WS2812-style RGB LED bitstreams; the receiving end of the LED drive line.
- Samples an external data line and measures each high pulse in clk cycles to decode bits. It assembles 24-bit GRB words and detects the long-low latch (reset) interval that ends a frame.
- Used for loopback verification of on-board LED drivers and for daisy-chain monitoring.
- clk is nominally 100 MHz (10 ns); defaults are sized for that.

---
 rtl/ws2812_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_rx.sv
// WS2812-style single-wire NRZ receiver: measures high-pulse widths to decode
// bits, assembles 24-bit GRB words and detects the long-low latch interval.
module ws2812_rx #(
  parameter int BIT_THRESH   = 60,
  parameter int MIN_HIGH     = 15,
  parameter int MAX_HIGH     = 120,
  parameter int RESET_CYCLES = 5000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        din,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic [7:0]  pix_index,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_SYNC_WAIT,
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] BIT_T   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_T   = CNT_W'(RESET_CYCLES);

  state_t             state, state_next;
  logic               din_m, din_s, din_d;
  logic               rise, fall, lat_hit, bit_val, word_full;
  logic [CNT_W-1:0]   hcnt, lcnt;
  logic [23:0]        shreg;
  logic [4:0]         bitcnt;
  logic [7:0]         word_cnt;
  logic               shift_en, err_set, frame_set, clr_frame;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // The edge cycle is itself the first cycle of the new level, so counters
  // restart at 1 and hold exactly the number of samples seen at the next edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      if (rise)                        hcnt <= CNT_W'(1);
      else if (din_s && hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
      if (fall)                        lcnt <= CNT_W'(1);
      else if (!din_s && lcnt != CNT_MAX) lcnt <= lcnt + CNT_W'(1);
    end
  end

  assign lat_hit   = ~din_s && (lcnt == RST_T);
  assign bit_val   = (hcnt >= BIT_T);
  assign word_full = shift_en && (bitcnt == 5'd23);
  assign busy      = (state == ST_HIGH) || (state == ST_LOW) || (state == ST_ERROR);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_SYNC_WAIT;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    err_set    = 1'b0;
    frame_set  = 1'b0;
    clr_frame  = 1'b0;
    unique case (state)
      ST_SYNC_WAIT: if (lat_hit) state_next = ST_IDLE;
      ST_IDLE:      if (rise) state_next = ST_HIGH;
      ST_HIGH: begin
        // Over-long pulses abort whether the line is still high or just fell.
        if (hcnt > MAX_T) begin
          err_set    = 1'b1;
          state_next = ST_ERROR;
        end else if (fall) begin
          if (hcnt < MIN_T) begin
            err_set    = 1'b1;
            state_next = ST_ERROR;
          end else begin
            shift_en   = 1'b1;
            state_next = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_next = ST_HIGH;
        end else if (lat_hit) begin
          frame_set  = 1'b1;
          clr_frame  = 1'b1;
          err_set    = (bitcnt != 5'd0);
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (lat_hit) begin
          clr_frame  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg      <= '0;
      bitcnt     <= '0;
      word_cnt   <= '0;
      pix_data   <= '0;
      pix_index  <= '0;
      pix_valid  <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= word_full;
      err        <= err_set;
      frame_done <= frame_set;
      if (shift_en) begin
        shreg <= {shreg[22:0], bit_val};
        if (word_full) begin
          pix_data  <= {shreg[22:0], bit_val};
          pix_index <= word_cnt;
          bitcnt    <= '0;
          if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
        end else begin
          bitcnt <= bitcnt + 5'd1;
        end
      end
      if (clr_frame) begin
        shreg     <= '0;
        bitcnt    <= '0;
        word_cnt  <= '0;
        pix_index <= '0;
      end
    end
  end

endmodule
